// File: rtl/ntt_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ntt_stream_bridge (with helper ntt_sb_fifo)
// Description : Host/NTT-core I/O bridge. Buffers host words in an input FIFO,
//               loads one frame into the core data memory, starts the core,
//               waits for completion and unloads the results into an output
//               FIFO that the host drains through a valid/ready handshake.
// Revision    : 1.0 - initial parametrised single-clock release
// ============================================================================

// ----------------------------------------------------------------------------
// Synchronous first-word-fall-through FIFO. The caller never pushes when full
// and never pops when empty, so no protection logic is needed here.
// ----------------------------------------------------------------------------
module ntt_sb_fifo #(
  parameter int W  = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage array: written on push only, never reset (contents are don't-care
  // while the occupancy says empty).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Head of queue is visible combinationally (fall-through).
  assign head = mem[rd_ptr];

endmodule

// ----------------------------------------------------------------------------
// Top level bridge.
// ----------------------------------------------------------------------------
module ntt_stream_bridge #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 2,
  parameter int ADDR_W  = 8,
  parameter int N_WORDS = 128,
  parameter int FIFO_AW = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      core_we,
  output logic [ADDR_W-1:0]         core_waddr,
  output logic [LANES*DATA_W-1:0]   core_wdata,
  output logic                      core_start,
  output logic                      core_mode,
  input  logic                      core_done,
  output logic                      core_re,
  output logic [ADDR_W-1:0]         core_raddr,
  input  logic [LANES*DATA_W-1:0]   core_rdata,
  output logic                      busy,
  output logic                      frame_done,
  output logic [FIFO_AW:0]          in_level,
  output logic [FIFO_AW:0]          out_level
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int DEPTH  = 2**FIFO_AW;

  localparam logic [FIFO_AW:0]   DEPTH_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW+1:0] DEPTH_OCC = (FIFO_AW+2)'(DEPTH);
  localparam logic [ADDR_W:0]    LAST_CNT  = (ADDR_W+1)'(N_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  logic [2:0]          state;
  logic [ADDR_W:0]     cnt;
  logic                mode_q;
  logic                pending;

  logic                in_push;
  logic                in_pop;
  logic [WORD_W-1:0]   in_head;
  logic                out_push;
  logic                out_pop;
  logic [FIFO_AW+1:0]  out_occ;

  // ---------------- input FIFO ----------------
  // in_ready looks only at occupancy, so a full FIFO refuses a push even in a
  // cycle where LOAD pops it.
  assign in_ready = (in_level != DEPTH_LVL);
  assign in_push  = in_valid && in_ready && !rst;
  assign in_pop   = (state == S_LOAD) && (in_level != '0) && !rst;

  ntt_sb_fifo #(
    .W  (WORD_W),
    .AW (FIFO_AW)
  ) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (in_data),
    .pop       (in_pop),
    .head      (in_head),
    .level     (in_level)
  );

  // ---------------- output FIFO ----------------
  // Read data returns one cycle after core_re; pending marks that word.
  assign out_valid = (out_level != '0);
  assign out_pop   = out_valid && out_ready && !rst;
  assign out_push  = pending && !rst;

  ntt_sb_fifo #(
    .W  (WORD_W),
    .AW (FIFO_AW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (core_rdata),
    .pop       (out_pop),
    .head      (out_data),
    .level     (out_level)
  );

  // Room check counts the word still in flight so the output FIFO can never
  // overflow, whatever the host does with out_ready.
  assign out_occ = {1'b0, out_level} + {{(FIFO_AW+1){1'b0}}, pending};

  // ---------------- core interface ----------------
  assign core_we    = in_pop;
  assign core_waddr = cnt[ADDR_W-1:0];
  assign core_wdata = in_head;
  assign core_re    = (state == S_UNLOAD) && (out_occ < DEPTH_OCC) && !rst;
  assign core_raddr = cnt[ADDR_W-1:0];
  assign core_start = (state == S_START) && !rst;
  assign core_mode  = mode_q;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_FLUSH) && !pending && !rst;

  // Tracks a read issued this cycle whose data lands in the output FIFO next.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= core_re;
    end
  end

  // Frame sequencer: load, start, wait, unload, flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            mode_q <= mode;
            cnt    <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_pop) begin
            cnt <= cnt + (ADDR_W+1)'(1);
            if (cnt == LAST_CNT) begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (core_re) begin
            cnt <= cnt + (ADDR_W+1)'(1);
            if (cnt == LAST_CNT) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!pending) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_stream_bridge
// Description : Self-checking bench for ntt_stream_bridge. Two instances share
//               the stimulus: A (N_WORDS=4, 8-deep FIFOs) and B (N_WORDS=8,
//               4-deep FIFOs); the one not selected is held in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stream_bridge;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, go, mode, in_valid, out_ready, core_done, rsel;
  logic [31:0] in_data, core_rdata;

  // instance A outputs
  logic        a_in_ready, a_out_valid, a_we, a_start, a_mode, a_re, a_busy, a_fd;
  logic [31:0] a_out_data, a_wdata;
  logic [7:0]  a_waddr, a_raddr;
  logic [3:0]  a_in_level, a_out_level;
  // instance B outputs
  logic        b_in_ready, b_out_valid, b_we, b_start, b_mode, b_re, b_busy, b_fd;
  logic [31:0] b_out_data, b_wdata;
  logic [7:0]  b_waddr, b_raddr;
  logic [2:0]  b_in_level, b_out_level;

  wire rst_a = rst | sel;
  wire rst_b = rst | ~sel;

  ntt_stream_bridge #(.DATA_W(16), .LANES(2), .ADDR_W(8), .N_WORDS(4), .FIFO_AW(3)) u_a (
    .clk(clk), .rst(rst_a), .go(go), .mode(mode), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_data(in_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .core_we(a_we),
    .core_waddr(a_waddr), .core_wdata(a_wdata), .core_start(a_start),
    .core_mode(a_mode), .core_done(core_done), .core_re(a_re),
    .core_raddr(a_raddr), .core_rdata(core_rdata), .busy(a_busy),
    .frame_done(a_fd), .in_level(a_in_level), .out_level(a_out_level));

  ntt_stream_bridge #(.DATA_W(16), .LANES(2), .ADDR_W(8), .N_WORDS(8), .FIFO_AW(2)) u_b (
    .clk(clk), .rst(rst_b), .go(go), .mode(mode), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_data(in_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .core_we(b_we),
    .core_waddr(b_waddr), .core_wdata(b_wdata), .core_start(b_start),
    .core_mode(b_mode), .core_done(core_done), .core_re(b_re),
    .core_raddr(b_raddr), .core_rdata(core_rdata), .busy(b_busy),
    .frame_done(b_fd), .in_level(b_in_level), .out_level(b_out_level));

  // outputs of the selected instance
  wire        m_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire        m_out_valid = sel ? b_out_valid : a_out_valid;
  wire        m_we        = sel ? b_we        : a_we;
  wire        m_start     = sel ? b_start     : a_start;
  wire        m_mode      = sel ? b_mode      : a_mode;
  wire        m_re        = sel ? b_re        : a_re;
  wire        m_busy      = sel ? b_busy      : a_busy;
  wire        m_fd        = sel ? b_fd        : a_fd;
  wire [31:0] m_out_data  = sel ? b_out_data  : a_out_data;
  wire [31:0] m_wdata     = sel ? b_wdata     : a_wdata;
  wire [7:0]  m_waddr     = sel ? b_waddr     : a_waddr;
  wire [7:0]  m_raddr     = sel ? b_raddr     : a_raddr;
  wire [3:0]  m_in_level  = sel ? {1'b0, b_in_level}  : a_in_level;
  wire [3:0]  m_out_level = sel ? {1'b0, b_out_level} : a_out_level;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core memory model: stores written words, returns a result word one cycle
  // after each read (address pattern, or stored word xor KEY).
  logic [31:0] cmem [256];
  always @(posedge clk) begin
    if (m_we) cmem[m_waddr] <= m_wdata;
    if (m_re) core_rdata <= rsel ? (cmem[m_raddr] ^ KEY) : (32'(m_raddr) * 32'h0001_0001);
  end

  // Reference model: two plain queues plus frame address counters.
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  int          wcnt = 0, rcnt = 0;
  logic        pend = 1'b0;

  always @(negedge clk) begin
    int   depth;
    int   occ;
    logic rdy;
    logic [31:0] tmp;
    depth = sel ? 4 : 8;
    if (rst) begin
      in_q.delete(); out_q.delete();
      wcnt = 0; rcnt = 0; pend = 1'b0;
    end else begin
      rdy = (in_q.size() != depth);
      occ = out_q.size() + int'(pend);
      check("in_level", 64'(m_in_level), 64'(in_q.size()));
      check("in_ready", 64'(m_in_ready), 64'(rdy));
      check("out_level", 64'(m_out_level), 64'(out_q.size()));
      check("out_valid", 64'(m_out_valid), 64'(out_q.size() != 0));
      if (m_we) begin
        if (in_q.size() == 0) begin
          check("we_when_empty", 64'(m_we), 64'(0));
        end else begin
          check("core_wdata", 64'(m_wdata), 64'(in_q[0]));
          tmp = in_q.pop_front();
        end
        check("core_waddr", 64'(m_waddr), 64'(wcnt));
        wcnt++;
      end
      if (in_valid && rdy) in_q.push_back(in_data);
      if (m_out_valid && out_ready && out_q.size() != 0) begin
        check("out_data", 64'(m_out_data), 64'(out_q[0]));
        tmp = out_q.pop_front();
      end
      if (m_re) begin
        check("read_room", 64'(occ < depth), 64'(1));
        check("core_raddr", 64'(m_raddr), 64'(rcnt));
        rcnt++;
      end
      if (pend) out_q.push_back(core_rdata);
      pend = m_re;
      if (m_fd) begin wcnt = 0; rcnt = 0; end
    end
  end

  logic [31:0] host_q[$];

  function automatic logic [31:0] word(input int i);
    return (32'(i + 1) << 16) | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1; in_data = w;
    while (!m_in_ready && n < 200) begin tick(); n++; end
    check("push_ready", 64'(m_in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    host_q.push_back(w);
  endtask

  task automatic start_frame(input bit m);
    go = 1'b1; mode = m; tick(); go = 1'b0; mode = 1'b0;
  endtask

  task automatic finish_frame(input bit m, input int nw, input bit rs, input bit rnd, input bit stall);
    int n, fd;
    logic [31:0] got[$];
    logic [31:0] hw, ew;
    rsel = rs;
    n = 0;
    while (!m_start && n < 300) begin tick(); n++; end
    check("start_seen", 64'(m_start), 64'(1));
    check("start_mode", 64'(m_mode), 64'(m));
    tick();
    check("start_one_cycle", 64'(m_start), 64'(0));
    for (int i = 0; i < 20; i++) begin
      go = (i == 10); mode = ~m; tick();
    end
    go = 1'b0; mode = 1'b0;
    check("wait_no_re", 64'(rcnt), 64'(0));
    check("wait_busy", 64'(m_busy), 64'(1));
    check("wait_mode", 64'(m_mode), 64'(m));
    core_done = 1'b1; tick(); core_done = 1'b0;
    if (stall) begin
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin go = (i == 0); mode = ~m; tick(); end
      go = 1'b0; mode = 1'b0;
      check("stall_reads", 64'(rcnt), 64'(4));
      check("stall_level", 64'(m_out_level), 64'(4));
      repeat (10) tick();
      check("stall_reads_hold", 64'(rcnt), 64'(4));
      check("stall_level_hold", 64'(m_out_level), 64'(4));
    end
    check("unload_mode", 64'(m_mode), 64'(m));
    fd = 0;
    for (int it = 0; it < 600 && !(got.size() >= nw && fd > 0); it++) begin
      go = (it == 0); mode = ~m;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_out_valid && out_ready) got.push_back(m_out_data);
      if (m_fd) fd++;
      tick();
    end
    go = 1'b0; mode = 1'b0; out_ready = 1'b0;
    check("drained_words", 64'(got.size()), 64'(nw));
    check("frame_done_pulses", 64'(fd), 64'(1));
    check("idle_after_frame", 64'(m_busy), 64'(0));
    for (int k = 0; k < nw; k++) begin
      hw = (host_q.size() != 0) ? host_q.pop_front() : 32'hDEAD_BEEF;
      ew = rs ? (hw ^ KEY) : (32'(k) * 32'h0001_0001);
      if (k < got.size()) check("result_word", 64'(got[k]), 64'(ew));
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    int          lvl;
    logic        rdy;
    logic        acc;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; go = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0; core_done = 1'b0; rsel = 1'b0;
    for (int i = 0; i < 9; i++)
      tbl[i] = '{1'b1, word(i), (i < 8) ? i + 1 : 8, (i + 1 < 8), (i < 8)};

    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 64'(m_busy), 64'(0));
    check("rst_in_ready", 64'(m_in_ready), 64'(1));
    check("rst_out_valid", 64'(m_out_valid), 64'(0));
    check("rst_in_level", 64'(m_in_level), 64'(0));
    check("rst_out_level", 64'(m_out_level), 64'(0));
    check("rst_core_we", 64'(m_we), 64'(0));
    check("rst_core_re", 64'(m_re), 64'(0));
    check("rst_core_start", 64'(m_start), 64'(0));
    check("rst_frame_done", 64'(m_fd), 64'(0));
    check("rst_core_mode", 64'(m_mode), 64'(0));

    // Fill the 8-deep input FIFO in IDLE; the 9th word must be refused.
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d;
      tick();
      check("tbl_in_level", 64'(m_in_level), 64'(tbl[i].lvl));
      check("tbl_in_ready", 64'(m_in_ready), 64'(tbl[i].rdy));
      if (tbl[i].acc) host_q.push_back(tbl[i].d);
    end
    // go with the refused word still offered: first LOAD pop + blocked push -> 7
    go = 1'b1; mode = 1'b0; tick(); go = 1'b0;
    check("load_level_full", 64'(m_in_level), 64'(8));
    check("load_busy", 64'(m_busy), 64'(1));
    check("load_we", 64'(m_we), 64'(1));
    check("load_waddr0", 64'(m_waddr), 64'(0));
    check("load_wdata0", 64'(m_wdata), 64'(32'h0001_0000));
    tick();
    check("pop_blocked_push_level", 64'(m_in_level), 64'(7));
    in_valid = 1'b0;
    finish_frame(1'b0, 4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) check("core_mem_word", 64'(cmem[k]), 64'(word(k)));

    // Second frame on A from the words left buffered, inverse mode.
    start_frame(1'b1);
    finish_frame(1'b1, 4, 1'b1, 1'b0, 1'b0);

    // Switch to B: 8-word frame through 4-deep FIFOs, output back-pressure.
    rst = 1'b1; sel = 1'b1; tick(); rst = 1'b0; host_q.delete();
    for (int i = 0; i < 4; i++) push_word($urandom);
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) push_word($urandom);
    finish_frame(1'b0, 8, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of UNLOAD after two reads.
    for (int i = 0; i < 4; i++) push_word($urandom);
    start_frame(1'b1);
    for (int i = 0; i < 4; i++) push_word($urandom);
    n = 0;
    while (!m_start && n < 300) begin tick(); n++; end
    check("rst_frame_start", 64'(m_start), 64'(1));
    repeat (3) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (rcnt < 2 && n < 50) begin tick(); n++; end
    check("reads_before_rst", 64'(rcnt), 64'(2));
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_busy", 64'(m_busy), 64'(0));
    check("abort_in_level", 64'(m_in_level), 64'(0));
    check("abort_out_level", 64'(m_out_level), 64'(0));
    check("abort_core_re", 64'(m_re), 64'(0));
    repeat (5) tick();
    check("abort_no_reads", 64'(rcnt), 64'(0));
    host_q.delete();

    // Randomised frames with random mode and random host back-pressure.
    for (int f = 0; f < 3; f++) begin
      bit m;
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) push_word($urandom);
      start_frame(m);
      for (int i = 0; i < 4; i++) push_word($urandom);
      finish_frame(m, 8, 1'b1, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
